// File: rtl/sobel_window_ctrl.sv
// rtl/sobel_window_ctrl.sv - Sobel 3x3 window controller: FIFO pop, line-buffer drive, gradient pipeline
// Optional feature macro: SOBEL_THRESH_EN (adds thresh port, binary 0/FF output)
module sobel_window_ctrl #(
   parameter int WIDTH      = 722,
   parameter int HEIGHT     = 540,
   parameter int DATA_WIDTH = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_empty,
   input  logic [DATA_WIDTH-1:0]     in_dout,
   output logic                      in_rd_en,
   output logic                      sr_en,
   output logic [DATA_WIDTH-1:0]     sr_din,
   input  logic [9*DATA_WIDTH-1:0]   win,
   input  logic                      out_full,
`ifdef SOBEL_THRESH_EN
   input  logic [DATA_WIDTH-1:0]     thresh,
`endif
   output logic                      out_wr_en,
   output logic [DATA_WIDTH-1:0]     out_din,
   output logic                      frame_done
);

   // gradient width holds +/-(4*max pixel); magnitude needs one more bit
   localparam int GW = DATA_WIDTH + 3;
   localparam int MW = GW + 1;
   localparam int CW = $clog2(WIDTH);
   localparam int RW = $clog2(HEIGHT);

   localparam logic [19:0] S_RUN   = 20'(WIDTH + 2);
   localparam logic [19:0] S_FLUSH = 20'(WIDTH * HEIGHT);
   localparam logic [19:0] S_END   = 20'(WIDTH * HEIGHT + WIDTH + 1);

   localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
   localparam logic [DATA_WIDTH-1:0] PIX_MAX = '1;

   typedef enum logic [1:0] {FILL, RUN, FLUSH} state_t;

   state_t state, next_state;
   logic [19:0] s, s_next, s_inc;
   logic adv, shift, tok;

   logic v0, v1, v2;
   logic [CW-1:0] col;
   logic [RW-1:0] row;

   logic [DATA_WIDTH-1:0] p [9];
   logic signed [GW-1:0] gx_c, gy_c, gx, gy;
   logic border1, last1;

   logic [GW-1:0] ax, ay;
   logic [MW-1:0] mag;
   logic [DATA_WIDTH-1:0] clamped, out_c;
   logic last2;

   function automatic logic [GW-1:0] ext(input logic [DATA_WIDTH-1:0] v);
      return GW'(v);
   endfunction

   // state and per-frame shift count register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= FILL;
         s     <= '0;
      end else begin
         state <= next_state;
         s     <= s_next;
      end
   end

   // shift decision, token creation, FSM next state and handshake outputs
   always_comb begin
      next_state = state;
      s_next     = s;
      s_inc      = s + 20'd1;
      adv        = !(v2 && out_full);
      shift      = adv && (state == FLUSH || !in_empty);
      tok        = 1'b0;
      if (shift) begin
         s_next = s_inc;
         case (state)
            FILL: begin
               if (s_inc == S_RUN) begin
                  next_state = RUN;
                  tok        = 1'b1;
               end
            end
            RUN: begin
               tok = 1'b1;
               if (s_inc == S_FLUSH) next_state = FLUSH;
            end
            FLUSH: begin
               tok = 1'b1;
               if (s_inc == S_END) begin
                  next_state = FILL;
                  s_next     = '0;
               end
            end
            default: next_state = FILL;
         endcase
      end
      sr_en      = shift;
      in_rd_en   = shift && (state != FLUSH);
      sr_din     = (state == FLUSH) ? '0 : in_dout;
      out_wr_en  = v2 && !out_full;
      frame_done = v2 && !out_full && last2;
   end

   // valid pipeline plus row/col of the token currently sitting in v0
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v0  <= 1'b0;
         v1  <= 1'b0;
         v2  <= 1'b0;
         col <= '0;
         row <= '0;
      end else if (adv) begin
         v0 <= tok;
         v1 <= v0;
         v2 <= v1;
         if (v0) begin
            if (col == COL_LAST) begin
               col <= '0;
               row <= (row == ROW_LAST) ? '0 : row + RW'(1);
            end else begin
               col <= col + CW'(1);
            end
         end
      end
   end

   // unpack the window and form both gradients
   always_comb begin
      for (int i = 0; i < 9; i++) p[i] = win[i*DATA_WIDTH +: DATA_WIDTH];
      gx_c = (ext(p[2]) + (ext(p[5]) << 1) + ext(p[8])) - (ext(p[0]) + (ext(p[3]) << 1) + ext(p[6]));
      gy_c = (ext(p[6]) + (ext(p[7]) << 1) + ext(p[8])) - (ext(p[0]) + (ext(p[1]) << 1) + ext(p[2]));
   end

   // stage 1: register gradients, border and end-of-frame flags
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gx      <= '0;
         gy      <= '0;
         border1 <= 1'b0;
         last1   <= 1'b0;
      end else if (adv && v0) begin
         gx      <= gx_c;
         gy      <= gy_c;
         border1 <= (row == '0) || (row == ROW_LAST) || (col == '0) || (col == COL_LAST);
         last1   <= (row == ROW_LAST) && (col == COL_LAST);
      end
   end

   // magnitude, clamp and border forcing
   always_comb begin
      ax      = gx[GW-1] ? $unsigned(-gx) : $unsigned(gx);
      ay      = gy[GW-1] ? $unsigned(-gy) : $unsigned(gy);
      mag     = {1'b0, ax} + {1'b0, ay};
      clamped = (mag > {{(MW-DATA_WIDTH){1'b0}}, PIX_MAX}) ? PIX_MAX : mag[DATA_WIDTH-1:0];
`ifdef SOBEL_THRESH_EN
      out_c   = border1 ? '0 : ((clamped >= thresh) ? PIX_MAX : '0);
`else
      out_c   = border1 ? '0 : clamped;
`endif
   end

   // stage 2: output register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_din <= '0;
         last2   <= 1'b0;
      end else if (adv && v1) begin
         out_din <= out_c;
         last2   <= last1;
      end
   end

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// tb/tb_sobel_window_ctrl.sv - directed self-checking bench for sobel_window_ctrl with line-buffer model
module tb_sobel_window_ctrl;
   localparam int W = 8;
   localparam int H = 6;
   localparam int DW = 8;
   localparam int STAGES = 2*W + 3;
   localparam int NPIX = W*H;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic in_empty, in_rd_en, sr_en, out_wr_en, frame_done;
   logic out_full = 1'b0;
   logic [DW-1:0] in_dout, sr_din, out_din;
   logic [9*DW-1:0] win;
`ifdef SOBEL_THRESH_EN
   logic [DW-1:0] thresh = 8'd128;
   localparam int RAMP_EXP = 0;
`else
   localparam int RAMP_EXP = 72;
`endif

   logic [DW-1:0] in_mem [512];
   logic [DW-1:0] sr [STAGES];
   int wr_cnt = 0;
   int rd_ptr = 0;
   logic gate = 1'b0;
   logic toggle_en = 1'b0;

   int n_assert = 0;
   int n_fail = 0;
   int cyc = 0;
   int sh_cnt = 0, flush_cnt = 0, flush_nz = 0, pop_cnt = 0, fd_bad = 0;
   int outs[$];
   int fd_idx[$];
   int sh_cyc[$];
   int push_cyc[$];

   sobel_window_ctrl #(.WIDTH(W), .HEIGHT(H), .DATA_WIDTH(DW)) dut (
      .clk(clk),
      .rst(rst),
      .in_empty(in_empty),
      .in_dout(in_dout),
      .in_rd_en(in_rd_en),
      .sr_en(sr_en),
      .sr_din(sr_din),
      .win(win),
      .out_full(out_full),
`ifdef SOBEL_THRESH_EN
      .thresh(thresh),
`endif
      .out_wr_en(out_wr_en),
      .out_din(out_din),
      .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   assign in_empty = gate || (rd_ptr >= wr_cnt);
   assign in_dout  = in_mem[rd_ptr[8:0]];

   for (genvar r = 0; r < 3; r++) begin : g_r
      for (genvar c = 0; c < 3; c++) begin : g_c
         assign win[(r*3+c)*DW +: DW] = sr[(2-r)*W + (2-c)];
      end
   end

   // upstream FIFO read pointer, line-buffer shift register, cycle counter, empty gating
   always @(posedge clk) begin
      cyc <= cyc + 1;
      gate <= toggle_en ? ~gate : 1'b0;
      if (rst) rd_ptr <= 0;
      else if (in_rd_en) rd_ptr <= rd_ptr + 1;
      if (sr_en) begin
         for (int i = STAGES-1; i > 0; i--) sr[i] <= sr[i-1];
         sr[0] <= sr_din;
      end
   end

   // mid-cycle monitor of shifts, pops and pushes
   always @(negedge clk) begin
      if (!rst) begin
         if (sr_en) begin
            sh_cnt <= sh_cnt + 1;
            sh_cyc.push_back(cyc);
            if (!in_rd_en) begin
               flush_cnt <= flush_cnt + 1;
               if (sr_din != 0) flush_nz <= flush_nz + 1;
            end
         end
         if (in_rd_en) pop_cnt <= pop_cnt + 1;
         if (out_wr_en) begin
            outs.push_back(int'(out_din));
            push_cyc.push_back(cyc);
            if (frame_done) fd_idx.push_back(outs.size() - 1);
         end
         if (frame_done && !out_wr_en) fd_bad <= fd_bad + 1;
      end
   end

   task automatic chk(input string tag, input int obs, input int exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int ref_pix(input int base, input int k);
      int r, c, gx, gy, m;
      r = k / W;
      c = k % W;
      if (r == 0 || r == H-1 || c == 0 || c == W-1) return 0;
      gx = 0;
      gy = 0;
      for (int dr = -1; dr <= 1; dr++) begin
         for (int dc = -1; dc <= 1; dc++) begin
            int v;
            v = int'(in_mem[base + (r+dr)*W + c + dc]);
            gx += dc * ((dr == 0) ? 2 : 1) * v;
            gy += dr * ((dc == 0) ? 2 : 1) * v;
         end
      end
      m = ((gx < 0) ? -gx : gx) + ((gy < 0) ? -gy : gy);
      if (m > 255) m = 255;
`ifdef SOBEL_THRESH_EN
      m = (m >= 128) ? 255 : 0;
`endif
      return m;
   endfunction

   // kind 0 flat 100, 1 vertical edge, 2 ramp
   task automatic load_frame(input int base, input int kind);
      for (int k = 0; k < NPIX; k++) begin
         int r, c;
         r = k / W;
         c = k % W;
         case (kind)
            0: in_mem[base+k] = 8'd100;
            1: in_mem[base+k] = (c < 4) ? 8'd0 : 8'd200;
            default: in_mem[base+k] = 8'(r*8 + c);
         endcase
      end
   endtask

   task automatic wait_outs(input int target, input int budget, input string tag);
      int k;
      k = 0;
      while (outs.size() < target && k < budget) begin
         @(posedge clk);
         k++;
      end
      chk(tag, (outs.size() >= target) ? 1 : 0, 1);
      @(posedge clk);
      #1;
   endtask

   task automatic check_frame(input int ob, input int mbase, input string tag);
      for (int k = 0; k < NPIX; k++)
         chk($sformatf("%s[%0d]", tag, k), (ob + k < outs.size()) ? outs[ob+k] : -1, ref_pix(mbase, k));
   endtask

   initial begin
      int ob, fb, flb, fnb, shb, pb, osnap, psnap, k;

      // reset
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_sr_en", int'(sr_en), 0);
      chk("rst_in_rd_en", int'(in_rd_en), 0);
      chk("rst_out_wr_en", int'(out_wr_en), 0);
      chk("rst_out_din", int'(out_din), 0);
      chk("rst_frame_done", int'(frame_done), 0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // flat frame
      ob = outs.size(); fb = fd_idx.size(); flb = flush_cnt; fnb = flush_nz;
      shb = sh_cyc.size(); pb = push_cyc.size();
      load_frame(0, 0);
      wr_cnt = 48;
      wait_outs(ob + NPIX, 400, "flat_timeout");
      repeat (10) @(posedge clk);
      #1;
      chk("flat_count", outs.size(), ob + NPIX);
      check_frame(ob, 0, "flat");
      chk("flat_fd_count", fd_idx.size() - fb, 1);
      chk("flat_fd_pos", (fd_idx.size() > fb) ? fd_idx[fb] : -1, ob + 47);
      chk("flat_flush_shifts", flush_cnt - flb, 9);
      chk("flat_flush_zero", flush_nz - fnb, 0);
      chk("flat_latency", push_cyc[pb] - sh_cyc[shb + 9], 3);

      // vertical edge
      ob = outs.size();
      load_frame(48, 1);
      wr_cnt = 96;
      wait_outs(ob + NPIX, 400, "edge_timeout");
      check_frame(ob, 48, "edge");
      chk("edge_r2c3", outs[ob + 2*8 + 3], 255);
      chk("edge_r2c4", outs[ob + 2*8 + 4], 255);
      chk("edge_r3c2", outs[ob + 3*8 + 2], 0);
      chk("edge_r3c5", outs[ob + 3*8 + 5], 0);
      chk("edge_r0c3", outs[ob + 0*8 + 3], 0);
      chk("edge_r5c4", outs[ob + 5*8 + 4], 0);

      // ramp with a 20-cycle output stall mid-frame
      ob = outs.size();
      load_frame(96, 2);
      wr_cnt = 144;
      wait_outs(ob + 20, 200, "stall_pre_timeout");
      out_full = 1'b1;
      osnap = outs.size();
      psnap = pop_cnt;
      repeat (20) @(posedge clk);
      #1;
      chk("stall_no_pops", pop_cnt - psnap, 0);
      chk("stall_no_push", outs.size() - osnap, 0);
      out_full = 1'b0;
      wait_outs(ob + NPIX, 400, "ramp_timeout");
      check_frame(ob, 96, "ramp");
      chk("ramp_r1c1", outs[ob + 1*8 + 1], RAMP_EXP);
      chk("ramp_r4c6", outs[ob + 4*8 + 6], RAMP_EXP);
      chk("ramp_r1c0", outs[ob + 1*8 + 0], 0);

      // two back-to-back frames with upstream empty every other cycle
      ob = outs.size(); fb = fd_idx.size();
      load_frame(144, 1);
      load_frame(192, 2);
      toggle_en = 1'b1;
      wr_cnt = 240;
      wait_outs(ob + 2*NPIX, 1200, "b2b_timeout");
      toggle_en = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      chk("b2b_count", outs.size(), ob + 2*NPIX);
      check_frame(ob, 144, "b2b_f0");
      check_frame(ob + NPIX, 192, "b2b_f1");
      chk("b2b_fd_count", fd_idx.size() - fb, 2);
      chk("b2b_fd0_pos", (fd_idx.size() > fb) ? fd_idx[fb] : -1, ob + 47);
      chk("b2b_fd1_pos", (fd_idx.size() > fb + 1) ? fd_idx[fb+1] : -1, ob + 95);

      // reset at s=30 then one clean flat frame
      shb = sh_cnt;
      load_frame(240, 1);
      wr_cnt = 288;
      k = 0;
      while (sh_cnt - shb < 30 && k < 200) begin
         @(posedge clk);
         k++;
      end
      chk("rst_mid_reach_s30", sh_cnt - shb, 30);
      #1;
      rst = 1'b1;
      wr_cnt = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_mid_out_wr_en", int'(out_wr_en), 0);
      rst = 1'b0;
      ob = outs.size(); fb = fd_idx.size();
      load_frame(0, 0);
      wr_cnt = 48;
      wait_outs(ob + NPIX, 400, "rst_frame_timeout");
      repeat (20) @(posedge clk);
      #1;
      chk("rst_frame_count", outs.size(), ob + NPIX);
      check_frame(ob, 0, "rst_frame");
      chk("rst_frame_fd_count", fd_idx.size() - fb, 1);
      chk("fd_without_push", fd_bad, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
